cycle_ctl: RTL and testbench

Parametrised bus-cycle termination controller for the Playground 68030 board. It is the successor to the fixed termination and timeout glue in the system controller. Active-low region selects from the address decoder feed a per-region wait-state sequencer, which generates synchronous (STERM) or asynchronous (DSACK) termination. The block also provides a configurable bus-error watchdog and a boot-overlay flag covering the first N bus cycles after reset.

---
 rtl/cycle_ctl.sv | 205 ++++++++++++++++++++
 tb/tb_cycle_ctl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_ctl.sv
// cycle_ctl: 68030 bus-cycle termination controller.
// Per-region wait-state sequencer driving STERM (sync) or DSACK (async),
// a bus-error watchdog on /AS, and a boot-overlay flag for the first
// BOOT_CYCLES completed bus cycles after reset.
// Optional: define CYCLE_CTL_FAULT_CAPTURE_EN to latch the select
// pattern seen when the watchdog fires (FAULT_VALID / FAULT_SEL).
module cycle_ctl #(
   parameter int NREGIONS       = 4,
   parameter int WAIT_W         = 3,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int BOOT_CYCLES    = 4
) (
   input  logic                       CPU_CLK,
   input  logic                       nRST,
   input  logic                       nAS,
   input  logic [NREGIONS-1:0]        nSEL,
   input  logic [NREGIONS*WAIT_W-1:0] WAIT,
   input  logic [NREGIONS-1:0]        SYNC,
   input  logic [2*NREGIONS-1:0]      PORTSZ,
   output logic                       STERM,
   output logic [1:0]                 DSACK,
   output logic                       BERR,
   output logic                       BOOT_OVL,
   input  logic                       FAULT_CLR,
   output logic                       FAULT_VALID,
   output logic [NREGIONS-1:0]        FAULT_SEL
);

   localparam logic [WAIT_W-1:0] CNT_ONE  = WAIT_W'(1);
   localparam logic [9:0]        WD_LAST  = 10'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]        BOOT_MAX = 4'(BOOT_CYCLES);

   typedef enum logic [2:0] {S_IDLE, S_WAITS, S_TERM, S_HOLD, S_UNSEL} state_t;

   state_t            r_state;
   logic [WAIT_W-1:0] r_cnt;
   logic              r_sync;
   logic [1:0]        r_psz;
   logic              r_sterm;
   logic [1:0]        r_dsack;
   logic [9:0]        r_wd;
   logic              r_berr;
   logic [3:0]        r_boot;
   logic              r_prev_low;
   logic              r_boot_ovl;

   int                w_hits;
   logic              w_one_hot;
   logic [WAIT_W-1:0] w_wait;
   logic              w_sync;
   logic [1:0]        w_psz;
   logic              w_term_now;
   logic              w_frozen;
   logic              w_berr_set;
   logic [3:0]        w_boot_nxt;

   // Decode the selected region's attributes; 00 port size means 32-bit
   always_comb begin
      w_hits = 0;
      w_wait = '0;
      w_sync = 1'b0;
      w_psz  = 2'b11;
      for (int i = 0; i < NREGIONS; i++) begin
         if (!nSEL[i]) begin
            w_hits = w_hits + 1;
            w_wait = WAIT[i*WAIT_W +: WAIT_W];
            w_sync = SYNC[i];
            w_psz  = (PORTSZ[2*i +: 2] == 2'b00) ? 2'b11 : PORTSZ[2*i +: 2];
         end
      end
   end

   assign w_one_hot  = (w_hits == 1);
   // A terminator goes out on this edge (zero-wait start or last wait state)
   assign w_term_now = !nAS &&
                       (((r_state == S_IDLE) && w_one_hot && (w_wait == '0)) ||
                        ((r_state == S_WAITS) && (r_cnt == CNT_ONE)));
   // Once terminated, the watchdog stops counting for the rest of the cycle
   assign w_frozen   = (r_state == S_TERM) || (r_state == S_HOLD);
   // Terminator beats a coincident timeout
   assign w_berr_set = !nAS && !r_berr && !w_frozen && !w_term_now && (r_wd == WD_LAST);

   // Wait-state sequencer with registered terminator outputs
   always_ff @(posedge CPU_CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_sync  <= 1'b0;
         r_psz   <= 2'b00;
         r_sterm <= 1'b0;
         r_dsack <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!nAS) begin
                  if (!w_one_hot) begin
                     r_state <= S_UNSEL;
                  end else begin
                     r_sync <= w_sync;
                     r_psz  <= w_psz;
                     if (w_wait == '0) begin
                        r_state <= S_TERM;
                        if (w_sync) r_sterm <= 1'b1;
                        else        r_dsack <= w_psz;
                     end else begin
                        r_cnt   <= w_wait;
                        r_state <= S_WAITS;
                     end
                  end
               end
            end
            S_WAITS: begin
               if (nAS) begin
                  r_state <= S_IDLE;               // aborted cycle
               end else if (r_cnt == CNT_ONE) begin
                  r_state <= S_TERM;
                  if (r_sync) r_sterm <= 1'b1;
                  else        r_dsack <= r_psz;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            S_TERM: begin
               if (r_sync) begin
                  // STERM is a single-cycle pulse; skip HOLD if /AS already gone
                  r_sterm <= 1'b0;
                  r_state <= nAS ? S_IDLE : S_HOLD;
               end else if (nAS) begin
                  r_dsack <= 2'b00;
                  r_state <= S_IDLE;
               end
            end
            S_HOLD:  if (nAS) r_state <= S_IDLE;
            S_UNSEL: if (nAS) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Watchdog: count /AS-low edges, raise BERR at the limit, clear on /AS high
   always_ff @(posedge CPU_CLK or negedge nRST) begin
      if (!nRST) begin
         r_wd   <= '0;
         r_berr <= 1'b0;
      end else if (nAS) begin
         r_wd   <= '0;
         r_berr <= 1'b0;
      end else begin
         if (w_berr_set) r_berr <= 1'b1;
         if (!w_frozen && !r_berr) r_wd <= r_wd + 10'd1;
      end
   end

   // Completed-cycle count, saturating at BOOT_CYCLES
   always_comb begin
      w_boot_nxt = r_boot;
      if (nAS && r_prev_low && (r_boot < BOOT_MAX)) w_boot_nxt = r_boot + 4'd1;
   end

   // Boot overlay flag tracks the completed-cycle count
   always_ff @(posedge CPU_CLK or negedge nRST) begin
      if (!nRST) begin
         r_boot     <= '0;
         r_prev_low <= 1'b0;
         r_boot_ovl <= (BOOT_CYCLES != 0);
      end else begin
         r_boot     <= w_boot_nxt;
         r_prev_low <= !nAS;
         r_boot_ovl <= (w_boot_nxt < BOOT_MAX);
      end
   end

`ifdef CYCLE_CTL_FAULT_CAPTURE_EN
   logic                r_fault_vld;
   logic [NREGIONS-1:0] r_fault_sel;

   // First timeout wins until cleared; a fault coinciding with clear is kept
   always_ff @(posedge CPU_CLK or negedge nRST) begin
      if (!nRST) begin
         r_fault_vld <= 1'b0;
         r_fault_sel <= '0;
      end else if (w_berr_set && (!r_fault_vld || FAULT_CLR)) begin
         r_fault_vld <= 1'b1;
         r_fault_sel <= ~nSEL;
      end else if (FAULT_CLR) begin
         r_fault_vld <= 1'b0;
         r_fault_sel <= '0;
      end
   end

   assign FAULT_VALID = r_fault_vld;
   assign FAULT_SEL   = r_fault_sel;
`else
   logic w_unused_clr;
   assign w_unused_clr = FAULT_CLR;
   assign FAULT_VALID  = 1'b0;
   assign FAULT_SEL    = '0;
`endif

   assign STERM    = r_sterm;
   assign DSACK    = r_dsack;
   assign BERR     = r_berr;
   assign BOOT_OVL = r_boot_ovl;

endmodule

// File: tb/tb_cycle_ctl.sv
// tb_cycle_ctl: directed bench for cycle_ctl. Two instances share stimulus
// (timeouts 64 and 8); a cycle-level model predicts every output after each
// rising edge, and literal checks pin the key timing points.
module tb_cycle_ctl;

   localparam int NR   = 4;
   localparam int WW   = 3;
   localparam int BOOT = 4;
   localparam int TA   = 64;
   localparam int TB   = 8;

   logic            clk = 1'b0;
   logic            nRST = 1'b1;
   logic            nAS = 1'b1;
   logic            FAULT_CLR = 1'b0;
   logic [NR-1:0]   nSEL = '1;
   logic [NR-1:0]   SYNC;
   logic [NR*WW-1:0] WAIT;
   logic [2*NR-1:0] PORTSZ;

   logic            sterm_a, sterm_b, berr_a, berr_b, boot_a, boot_b, fv_a, fv_b;
   logic [1:0]      dsack_a, dsack_b;
   logic [NR-1:0]   fsel_a, fsel_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cycle_ctl #(.NREGIONS(NR), .WAIT_W(WW), .TIMEOUT_CYCLES(TA), .BOOT_CYCLES(BOOT)) dut_a (
      .CPU_CLK(clk), .nRST(nRST), .nAS(nAS), .nSEL(nSEL), .WAIT(WAIT), .SYNC(SYNC),
      .PORTSZ(PORTSZ), .STERM(sterm_a), .DSACK(dsack_a), .BERR(berr_a), .BOOT_OVL(boot_a),
      .FAULT_CLR(FAULT_CLR), .FAULT_VALID(fv_a), .FAULT_SEL(fsel_a));

   cycle_ctl #(.NREGIONS(NR), .WAIT_W(WW), .TIMEOUT_CYCLES(TB), .BOOT_CYCLES(BOOT)) dut_b (
      .CPU_CLK(clk), .nRST(nRST), .nAS(nAS), .nSEL(nSEL), .WAIT(WAIT), .SYNC(SYNC),
      .PORTSZ(PORTSZ), .STERM(sterm_b), .DSACK(dsack_b), .BERR(berr_b), .BOOT_OVL(boot_b),
      .FAULT_CLR(FAULT_CLR), .FAULT_VALID(fv_b), .FAULT_SEL(fsel_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- cycle-level model ----------------
   // m_n counts consecutive edges with /AS low (edge E -> 1); a terminator is
   // due at m_n == WAIT+1, a timeout at m_n == T unless the terminator came first.
   int            m_n;
   bit            m_prev_low;
   bit            m_v;
   int            m_w;
   bit            m_sy;
   logic [1:0]    m_ps;
   int            m_boot;
   bit            m_fv [2];
   logic [NR-1:0] m_fsel [2];
   logic          e_sterm;
   logic [1:0]    e_dsack;
   logic          e_berr [2];
   logic          e_boot;

   task automatic model_reset();
      m_n = 0; m_prev_low = 0; m_v = 0; m_w = 0; m_sy = 0; m_ps = 2'b00; m_boot = 0;
      e_sterm = 0; e_dsack = 2'b00; e_boot = (BOOT != 0);
      for (int j = 0; j < 2; j++) begin
         m_fv[j] = 0; m_fsel[j] = '0; e_berr[j] = 0;
      end
   endtask

   task automatic model_step();
      int  hits, idx, tt;
      bit  covered;
      bit  fset [2];
      hits = 0; idx = 0;
      fset[0] = 0; fset[1] = 0;
      if (!nAS) begin
         m_n++;
         if (m_n == 1) begin
            for (int i = 0; i < NR; i++) if (!nSEL[i]) begin hits++; idx = i; end
            m_v  = (hits == 1);
            m_w  = int'(WAIT[idx*WW +: WW]);
            m_sy = SYNC[idx];
            m_ps = (PORTSZ[2*idx +: 2] == 2'b00) ? 2'b11 : PORTSZ[2*idx +: 2];
         end
         e_sterm = m_v && m_sy && (m_n == m_w + 1);
         e_dsack = (m_v && !m_sy && (m_n >= m_w + 1)) ? m_ps : 2'b00;
         for (int j = 0; j < 2; j++) begin
            tt = (j == 0) ? TA : TB;
            covered = m_v && (m_w + 1 <= tt);
            e_berr[j] = (m_n >= tt) && !covered;
            fset[j]   = (m_n == tt) && !covered;
         end
      end else begin
         if (m_prev_low && m_boot < BOOT) m_boot++;
         m_n = 0;
         e_sterm = 0; e_dsack = 2'b00; e_berr[0] = 0; e_berr[1] = 0;
      end
`ifdef CYCLE_CTL_FAULT_CAPTURE_EN
      for (int j = 0; j < 2; j++) begin
         if (fset[j] && (!m_fv[j] || FAULT_CLR)) begin
            m_fv[j] = 1; m_fsel[j] = ~nSEL;
         end else if (FAULT_CLR) begin
            m_fv[j] = 0; m_fsel[j] = '0;
         end
      end
`endif
      m_prev_low = !nAS;
      e_boot = (m_boot < BOOT);
   endtask

   task automatic compare_all();
      chk("sterm_a", sterm_a, e_sterm);   chk("sterm_b", sterm_b, e_sterm);
      chk("dsack_a", dsack_a, e_dsack);   chk("dsack_b", dsack_b, e_dsack);
      chk("berr_a", berr_a, e_berr[0]);   chk("berr_b", berr_b, e_berr[1]);
      chk("boot_a", boot_a, e_boot);      chk("boot_b", boot_b, e_boot);
      chk("fvalid_a", fv_a, m_fv[0]);     chk("fvalid_b", fv_b, m_fv[1]);
      chk("fsel_a", fsel_a, m_fsel[0]);   chk("fsel_b", fsel_b, m_fsel[1]);
   endtask

   // Model update on each rising edge, compare just after it
   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge nRST);
         if (!nRST) begin
            model_reset();
         end else begin
            model_step();
            #1;
            if (nRST) compare_all();
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic edges(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic start(input logic [NR-1:0] s);
      nAS = 1'b0; nSEL = s;
   endtask

   task automatic release_as();
      nAS = 1'b1; nSEL = '1;
   endtask

   initial begin
      SYNC   = 4'b0111;                           // r3 async, r2..r0 sync
      WAIT   = {3'd2, 3'd3, 3'd0, 3'd1};          // r3..r0
      PORTSZ = {2'b10, 2'b11, 2'b11, 2'b00};      // r3..r0
      nRST   = 1'b0;
      #12;
      chk("rst_sterm", sterm_a, 0);
      chk("rst_dsack", dsack_a, 0);
      chk("rst_berr", berr_a, 0);
      chk("rst_boot", boot_a, 1);
      chk("rst_fvalid", fv_a, 0);
      @(negedge clk); nRST = 1'b1;
      edges(1);

      // Boot overlay over five region-0 cycles (sync, one wait state)
      for (int c = 0; c < 5; c++) begin
         start(4'b1110);
         edges(2);
         if (c == 0) chk("r0_sterm_e1", sterm_a, 1);
         edges(1);
         if (c == 0) chk("r0_sterm_e2", sterm_a, 0);
         if (c == 3) chk("boot_in_4th", boot_a, 1);
         release_as();
         edges(1);
         if (c == 3) chk("boot_after_4th", boot_a, 0);
      end
      chk("boot_after_5th", boot_a, 0);

      // Region 1: sync, zero wait
      start(4'b1101);
      edges(1); chk("r1_sterm_e0", sterm_a, 1);
      edges(1); chk("r1_sterm_e1", sterm_a, 0);
      edges(1); release_as(); edges(1);

      // Region 2: sync, three waits; select dropped mid-cycle is ignored
      start(4'b1011);
      edges(1); nSEL = '1;
      edges(2); chk("r2_sterm_e2", sterm_a, 0);
      edges(1); chk("r2_sterm_e3", sterm_a, 1);
      edges(1); chk("r2_sterm_e4", sterm_a, 0);
      release_as(); edges(1);

      // Region 3: async 16-bit, two waits, /AS held 100 edges
      start(4'b0111);
      edges(2);  chk("r3_dsack_e1", dsack_a, 2'b00);
      edges(1);  chk("r3_dsack_e2", dsack_a, 2'b10);
      edges(98); chk("r3_dsack_e100", dsack_a, 2'b10);
      chk("r3_noberr_a", berr_a, 0);
      chk("r3_noberr_b", berr_b, 0);
      release_as();
      edges(1); chk("r3_dsack_clr", dsack_a, 2'b00);
      // back-to-back async cycle
      start(4'b0111);
      edges(3); chk("b2b_dsack", dsack_a, 2'b10);
      release_as(); edges(1);

      // Unselected cycle: watchdog only
      start(4'b1111);
      edges(63); chk("unsel_berr_e62", berr_a, 0);
      edges(1);  chk("unsel_berr_e63", berr_a, 1);
      edges(5);
      release_as();
      edges(1); chk("unsel_berr_clr", berr_a, 0);
`ifdef CYCLE_CTL_FAULT_CAPTURE_EN
      chk("fault_valid", fv_a, 1);
      chk("fault_sel", fsel_a, 4'b0000);
`else
      chk("fault_valid_off", fv_a, 0);
`endif
      FAULT_CLR = 1'b1; edges(1); FAULT_CLR = 1'b0;
      chk("fault_cleared", fv_a, 0);

      // Multiple selects: treated as unselected
      start(4'b1100);
      edges(10); chk("multi_berr_b", berr_b, 1);
      chk("multi_nodsack", dsack_b, 2'b00);
`ifdef CYCLE_CTL_FAULT_CAPTURE_EN
      chk("multi_fsel_b", fsel_b, 4'b0011);
`endif
      release_as(); edges(1);

      // Race: WAIT=7 against timeout 8 on dut_b
      WAIT[11:9] = 3'd7;
      start(4'b0111);
      edges(7); chk("race_dsack_e6", dsack_b, 2'b00);
      edges(1); chk("race_dsack_e7", dsack_b, 2'b10);
      chk("race_berr_e7", berr_b, 0);
      edges(4); chk("race_berr_late", berr_b, 0);
      release_as(); edges(1);
      WAIT[11:9] = 3'd2;

      // Aborted cycle in WAITS
      start(4'b1011);
      edges(2); release_as();
      edges(1); chk("abort_sterm", sterm_a, 0);
      edges(3); chk("abort_sterm_late", sterm_a, 0);

      // Reset pulse during WAITS
      start(4'b1011);
      edges(2);
      #2 nRST = 1'b0;
      #1;
      chk("rst2_sterm", sterm_a, 0);
      chk("rst2_dsack", dsack_a, 0);
      chk("rst2_berr", berr_a, 0);
      chk("rst2_boot", boot_a, 1);
      chk("rst2_fvalid", fv_a, 0);
      release_as();
      @(negedge clk); nRST = 1'b1;
      edges(1); chk("rst2_boot_after", boot_a, 1);

      // One more zero-wait sync cycle after reset
      start(4'b1101);
      edges(1); chk("post_rst_sterm", sterm_a, 1);
      edges(1); release_as(); edges(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
